// File: rtl/piano_pkg.sv
// ---------------------------------------------------------------------------
// piano_pkg
//   Types and constants shared by the piano recorder/playback blocks.
//     note_code_t        : packed {octave[2:0], note[2:0]} note code
//     REST, NOTE_C..B    : note field values (0 = rest)
//     OCT_MIN/MAX/DEF    : legal octave range and the reference octave
//     base_half_period() : reference-octave (octave 4) half periods in clk
//                          cycles at 100 MHz
//     is_rest()          : true for codes that must stay silent
//     tone_state_t       : tone_gen IDLE/PLAY state encoding
// ---------------------------------------------------------------------------
package piano_pkg;

    typedef struct packed {
        logic [2:0] octave;
        logic [2:0] note;
    } note_code_t;

    localparam logic [2:0] REST   = 3'd0;
    localparam logic [2:0] NOTE_C = 3'd1;
    localparam logic [2:0] NOTE_D = 3'd2;
    localparam logic [2:0] NOTE_E = 3'd3;
    localparam logic [2:0] NOTE_F = 3'd4;
    localparam logic [2:0] NOTE_G = 3'd5;
    localparam logic [2:0] NOTE_A = 3'd6;
    localparam logic [2:0] NOTE_B = 3'd7;

    localparam logic [2:0] OCT_MIN = 3'd1;
    localparam logic [2:0] OCT_MAX = 3'd7;
    localparam logic [2:0] OCT_DEF = 3'd4;

    // Largest octave-4 half period (C4 = 191113) fits in 18 bits.
    localparam int unsigned BASE_HP_W = 18;
    typedef logic [BASE_HP_W-1:0] base_hp_t;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } tone_state_t;

    function automatic base_hp_t base_half_period(input logic [2:0] note);
        case (note)
            NOTE_C:  return base_hp_t'(191113);
            NOTE_D:  return base_hp_t'(170262);
            NOTE_E:  return base_hp_t'(151686);
            NOTE_F:  return base_hp_t'(143173);
            NOTE_G:  return base_hp_t'(127551);
            NOTE_A:  return base_hp_t'(113636);
            NOTE_B:  return base_hp_t'(101239);
            default: return '0;
        endcase
    endfunction

    // Octave 0 is below OCT_MIN and is treated as silence, same as note 0.
    function automatic logic is_rest(input note_code_t code);
        return (code.note == REST) || (code.octave < OCT_MIN) || (code.octave > OCT_MAX);
    endfunction

endpackage

// File: rtl/note_period_lut.sv
// ---------------------------------------------------------------------------
// note_period_lut
//   Combinational map from a note code to its square-wave half period in
//   clk cycles. Octaves above 4 halve the period per step, octaves below 4
//   double it. Rests (note 0 or octave 0) map to 0.
// Ports
//   note_code : in  [5:0]      {octave[2:0], note[2:0]}
//   hp        : out [HP_W-1:0] half period in clk cycles, 0 for a rest
// ---------------------------------------------------------------------------
module note_period_lut
    import piano_pkg::*;
#(
    parameter int unsigned HP_W = 21
) (
    input  logic [5:0]      note_code,
    output logic [HP_W-1:0] hp
);

    note_code_t      code;
    logic [HP_W-1:0] base;

    assign code = note_code;
    assign base = HP_W'(base_half_period(code.note));

    // NOTE: every signal written in always_comb gets a default first so no
    // path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        hp = '0;
        if (!is_rest(code)) begin
            if (code.octave >= OCT_DEF) begin
                hp = base >> (code.octave - OCT_DEF);
            end else begin
                hp = base << (OCT_DEF - code.octave);
            end
        end
    end

endmodule

// File: rtl/tone_gen.sv
// ---------------------------------------------------------------------------
// tone_gen
//   Square-wave note synthesiser. Accepts one note code per valid/ready
//   handshake and drives a 1-bit square wave for NOTE_TICKS cycles. Rests
//   keep the block busy for the full duration with the output held low.
//   The wave starts low; the first rising edge comes one half period after
//   the accept edge.
// Parameters
//   NOTE_TICKS : note duration in clk cycles
//   HP_W       : half-period counter width (must hold C1 = 1_528_904)
// Ports
//   clk        : in  system clock
//   rst        : in  synchronous, active-high reset
//   note_valid : in  note_code is valid this cycle
//   note_code  : in  [5:0] {octave, note}
//   note_ready : out block accepts a note this cycle
//   stop       : in  abort current note and go silent
//   audio_out  : out square-wave output
//   busy       : out note or rest in progress
//   play_code  : out [5:0] code currently sounding, 0 when idle
// Configuration
//   TONE_GEN_RETRIGGER_EN : when defined, a new note is accepted while
//   playing and restarts the wave and duration immediately. When undefined,
//   notes are only accepted in IDLE and a note always runs to completion
//   unless stop or rst is asserted.
// ---------------------------------------------------------------------------
module tone_gen
    import piano_pkg::*;
#(
    parameter int unsigned NOTE_TICKS = 25_000_000,
    parameter int unsigned HP_W       = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       note_valid,
    input  logic [5:0] note_code,
    output logic       note_ready,
    input  logic       stop,
    output logic       audio_out,
    output logic       busy,
    output logic [5:0] play_code
);

    localparam int unsigned DUR_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam logic [DUR_W-1:0] LAST_TICK = DUR_W'(NOTE_TICKS - 1);
    localparam logic [HP_W-1:0]  HP_ONE    = HP_W'(1);
    localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

    tone_state_t      state_q, state_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic [HP_W-1:0]  phase_q, phase_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic             audio_q, audio_d;
    logic [5:0]       play_code_q, play_code_d;

    logic [HP_W-1:0]  lut_hp;
    logic             accept;

    note_period_lut #(
        .HP_W (HP_W)
    ) u_period_lut (
        .note_code (note_code),
        .hp        (lut_hp)
    );

`ifdef TONE_GEN_RETRIGGER_EN
    assign note_ready = !stop && !rst;
`else
    assign note_ready = (state_q == IDLE) && !stop && !rst;
`endif

    assign accept = note_valid && note_ready;

    always_comb begin
        state_d     = state_q;
        hp_d        = hp_q;
        phase_d     = phase_q;
        dur_d       = dur_q;
        audio_d     = audio_q;
        play_code_d = play_code_q;

        // note_ready is low while stop is high, so stop and accept never
        // coincide; stop is still checked first to make the priority explicit.
        if (stop) begin
            state_d     = IDLE;
            phase_d     = '0;
            dur_d       = '0;
            audio_d     = 1'b0;
            play_code_d = '0;
        end else if (accept) begin
            state_d     = PLAY;
            hp_d        = lut_hp;
            phase_d     = '0;
            dur_d       = '0;
            audio_d     = 1'b0;
            play_code_d = note_code;
        end else if (state_q == PLAY) begin
            // A zero half period marks a rest: the phase counter keeps
            // running but never toggles the output.
            if ((hp_q != '0) && (phase_q == hp_q - HP_ONE)) begin
                phase_d = '0;
                audio_d = !audio_q;
            end else begin
                phase_d = phase_q + HP_ONE;
            end

            // End of note overrides a toggle landing on the same edge.
            if (dur_q == LAST_TICK) begin
                state_d     = IDLE;
                audio_d     = 1'b0;
                play_code_d = '0;
            end else begin
                dur_d = dur_q + DUR_ONE;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values of the others, independent of ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hp_q        <= '0;
            phase_q     <= '0;
            dur_q       <= '0;
            audio_q     <= 1'b0;
            play_code_q <= '0;
        end else begin
            state_q     <= state_d;
            hp_q        <= hp_d;
            phase_q     <= phase_d;
            dur_q       <= dur_d;
            audio_q     <= audio_d;
            play_code_q <= play_code_d;
        end
    end

    assign audio_out = audio_q;
    assign busy      = (state_q == PLAY);
    assign play_code = play_code_q;

endmodule
